apb_master_ctrl: RTL and testbench

- APB requester side of the bridge; the counterpart of the APB responder that drives PRDATA.
- Accepts single read/write commands over a valid/ready handshake.
- Decodes each address to one of four one-hot PSELx lines and runs the APB2 SETUP/ENABLE sequence. There is no PREADY/PSLVERR, so every access is fixed-length.
- Returns read data and a decode-error flag on a one-cycle response pulse.
- Sits between the AHB-side pipeline and the four APB slaves.

---
 rtl/apb_pkg.sv | 20 ++
 rtl/apb_addr_decode.sv | 40 ++++
 rtl/apb_master_ctrl.sv | 125 ++++++++++++
 tb/tb_apb_master_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester (apb_master_ctrl).
// Contents: controller state enum, slave count, and the packed command payload.
package apb_pkg;

  localparam int unsigned APB_NUM_SLV = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ENABLE,
    ERR
  } apb_state_e;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decoder for the APB window.
// Ports:
//   addr - byte address of the incoming command
//   hit  - address falls in one of the APB_NUM_SLV slave regions
//   sel  - one-hot slave select (all zero on a miss)
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] SLV_SPAN  = 32'h0400_0000
) (
  input  logic [31:0]            addr,
  output logic                   hit,
  output logic [APB_NUM_SLV-1:0] sel
);

  // 33-bit bounds so the window end can never wrap back past zero.
  localparam logic [32:0] BASE_W  = {1'b0, BASE_ADDR};
  localparam logic [32:0] SPAN_W  = {1'b0, SLV_SPAN};
  localparam logic [32:0] SPAN2_W = SPAN_W << 1;
  localparam logic [32:0] SPAN3_W = SPAN2_W + SPAN_W;
  localparam logic [32:0] END_W   = BASE_W + (SPAN_W << 2);

  logic [32:0] addr_w;
  logic [32:0] offset;
  logic [1:0]  idx;

  // Region index by threshold compare; equivalent to offset / SLV_SPAN inside the window.
  always_comb begin
    addr_w = {1'b0, addr};
    offset = addr_w - BASE_W;
    hit    = (addr_w >= BASE_W) && (addr_w < END_W);
    if (offset >= SPAN3_W)      idx = 2'd3;
    else if (offset >= SPAN2_W) idx = 2'd2;
    else if (offset >= SPAN_W)  idx = 2'd1;
    else                        idx = 2'd0;
    sel = hit ? (APB_NUM_SLV'(1) << idx) : '0;
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB2 requester: takes single read/write commands over valid/ready, decodes
// the address to one of four slaves, runs a fixed SETUP/ENABLE access and
// returns a one-cycle response pulse (read data or decode error).
// Ports:
//   clock, reset                     - clock, async active-high reset
//   cmd_valid/cmd_ready              - command handshake
//   cmd_write/cmd_addr/cmd_wdata     - command payload
//   rsp_valid/rsp_rdata/rsp_err      - response pulse, data, decode error
//   PSELx/PENABLE/PWRITE/PADDR/PWDATA - APB request signals
//   PRDATA                           - APB read data from selected slave
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] SLV_SPAN  = 32'h0400_0000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [31:0]            cmd_addr,
  input  logic [31:0]            cmd_wdata,
  output logic                   rsp_valid,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic [APB_NUM_SLV-1:0] PSELx,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [31:0]            PADDR,
  output logic [31:0]            PWDATA,
  input  logic [31:0]            PRDATA
);

  apb_state_e             state;
  apb_cmd_t               cmd;
  logic                   hit;
  logic [APB_NUM_SLV-1:0] sel;
  logic                   accept;

  assign cmd    = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  assign accept = cmd_valid && cmd_ready;

  apb_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .SLV_SPAN  (SLV_SPAN)
  ) u_decode (
    .addr (cmd_addr),
    .hit  (hit),
    .sel  (sel)
  );

  // Controller FSM with registered APB and response outputs.
  // cmd_ready is registered alongside the state: high whenever the next state is IDLE or ENABLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PSELx     <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (accept && hit) begin
            PADDR     <= cmd.addr;
            PWRITE    <= cmd.write;
            PWDATA    <= cmd.wdata;
            PSELx     <= sel;
            state     <= SETUP;
            cmd_ready <= 1'b0;
          end else if (accept) begin
            state     <= ERR;
            cmd_ready <= 1'b0;
          end
        end
        SETUP: begin
          PENABLE   <= 1'b1;
          state     <= ENABLE;
          cmd_ready <= 1'b1;
        end
        ENABLE: begin
          // Access completes at this edge; a new command may launch in the same edge.
          PENABLE   <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= PWRITE ? '0 : PRDATA;
          PSELx     <= '0;
          state     <= IDLE;
          cmd_ready <= 1'b1;
          if (accept && hit) begin
            PADDR     <= cmd.addr;
            PWRITE    <= cmd.write;
            PWDATA    <= cmd.wdata;
            PSELx     <= sel;
            state     <= SETUP;
            cmd_ready <= 1'b0;
          end else if (accept) begin
            state     <= ERR;
            cmd_ready <= 1'b0;
          end
        end
        ERR: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Scoreboard bench for apb_master_ctrl: the driver pushes expected APB
// transfers and responses at accept time; monitors pop and compare.
module tb_apb_master_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [3:0]  PSELx;
  logic        PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } rsp_exp_t;

  typedef struct {
    logic [3:0]  sel;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          acc;
  } apb_exp_t;

  rsp_exp_t rsp_q[$];
  apb_exp_t apb_q[$];
  rsp_exp_t r;
  apb_exp_t e;

  apb_master_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSELx     (PSELx),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Slave model: valid data only during the access phase, junk otherwise.
  always_comb begin
    if (PENABLE && (PSELx != 4'b0000))
      PRDATA = (PADDR == 32'h8C00_0004) ? 32'h1234_5678 : (PADDR ^ 32'hA5A5_A5A5);
    else
      PRDATA = 32'hBAD0_BAD0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // sel == 0 marks an expected decode miss.
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] sel, input logic [31:0] exp_rd, output int acc);
    int n;
    rsp_exp_t re;
    apb_exp_t ae;
    n = 0;
    acc = -1;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: addr %h never accepted", a);
      cmd_valid = 1'b0;
    end else begin
      acc = cyc;
      re.rdata = (sel == 4'b0000 || w) ? 32'h0 : exp_rd;
      re.err   = (sel == 4'b0000);
      re.acc   = acc;
      rsp_q.push_back(re);
      if (sel != 4'b0000) begin
        ae.sel = sel; ae.write = w; ae.addr = a; ae.wdata = d; ae.acc = acc;
        apb_q.push_back(ae);
      end
      @(posedge clock);
    end
  endtask

  task automatic idle();
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || apb_q.size() != 0) && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("drain_pending", 32'(rsp_q.size() + apb_q.size()), 32'h0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_rsp_err"},   32'(rsp_err), 32'h0);
    chk({tag, "_psel"},      32'(PSELx), 32'h0);
    chk({tag, "_penable"},   32'(PENABLE), 32'h0);
    chk({tag, "_pwrite"},    32'(PWRITE), 32'h0);
    chk({tag, "_paddr"},     PADDR, 32'h0);
    chk({tag, "_pwdata"},    PWDATA, 32'h0);
  endtask

  // APB monitor: SETUP must be accept+1, ENABLE accept+2, fields as issued.
  always @(negedge clock) begin
    if (!reset && (PSELx != 4'b0000 || PENABLE)) begin
      if (apb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL apb_unexpected: psel=%b penable=%b with no pending transfer", PSELx, PENABLE);
      end else begin
        e = apb_q[0];
        chk("psel", 32'(PSELx), 32'(e.sel));
        chk("paddr", PADDR, e.addr);
        chk("pwrite", 32'(PWRITE), 32'(e.write));
        if (e.write) chk("pwdata", PWDATA, e.wdata);
        chk("apb_phase_cycle", 32'(cyc - e.acc), PENABLE ? 32'd2 : 32'd1);
        if (PENABLE) void'(apb_q.pop_front());
      end
    end
  end

  // Response monitor: hit responds at accept+3, miss at accept+2.
  always @(negedge clock) begin
    if (!reset && rsp_valid) begin
      if (rsp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: rdata=%h err=%b with nothing pending", rsp_rdata, rsp_err);
      end else begin
        r = rsp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, r.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(r.err));
        chk("rsp_latency", 32'(cyc - r.acc), r.err ? 32'd2 : 32'd3);
      end
    end
  end

  initial begin
    int a1, a2;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;

    #1 reset = 1'b1;
    #1 chk_all_zero("reset");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1 chk("cmd_ready_after_reset", 32'(cmd_ready), 32'h1);

    // Single write, then a read of the top slave.
    send(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b0001, 32'h0, a1);
    idle();
    drain();
    send(1'b0, 32'h8C00_0004, 32'h0, 4'b1000, 32'h1234_5678, a1);
    idle();
    drain();

    // Back-to-back read then write with cmd_valid held.
    send(1'b0, 32'h8400_0000, 32'h0, 4'b0010, 32'h21A5_A5A5, a1);
    send(1'b1, 32'h8800_0000, 32'h0BAD_F00D, 4'b0100, 32'h0, a2);
    idle();
    chk("b2b_accept_gap", 32'(a2 - a1), 32'd2);
    drain();

    // Unmapped addresses above and below the window.
    send(1'b0, 32'h9000_0000, 32'h0, 4'b0000, 32'h0, a1);
    idle();
    drain();
    send(1'b1, 32'h7FFF_FFFC, 32'h1111_2222, 4'b0000, 32'h0, a1);
    idle();
    drain();

    // Region boundaries.
    send(1'b0, 32'h8FFF_FFFC, 32'h0, 4'b1000, 32'h2A5A_5A59, a1);
    idle();
    drain();
    send(1'b0, 32'h83FF_FFFF, 32'h0, 4'b0001, 32'h265A_5A5A, a1);
    idle();
    drain();
    send(1'b1, 32'h8400_0000, 32'hCAFE_0001, 4'b0010, 32'h0, a1);
    idle();
    drain();
    send(1'b0, 32'hFFFF_FFFF, 32'h0, 4'b0000, 32'h0, a1);
    idle();
    drain();

    // Hit followed back-to-back by a miss.
    send(1'b0, 32'h8000_0000, 32'h0, 4'b0001, 32'h25A5_A5A5, a1);
    send(1'b1, 32'h7FFF_FFFC, 32'h3333_4444, 4'b0000, 32'h0, a2);
    idle();
    chk("hit_miss_accept_gap", 32'(a2 - a1), 32'd2);
    drain();

    // Leave non-zero response data, then reset in the middle of ENABLE.
    send(1'b0, 32'h83FF_FFFF, 32'h0, 4'b0001, 32'h265A_5A5A, a1);
    idle();
    drain();
    send(1'b1, 32'h8800_0008, 32'h5555_AAAA, 4'b0100, 32'h0, a1);
    idle();
    @(posedge clock);
    #1 chk("penable_before_reset", 32'(PENABLE), 32'h1);
    reset = 1'b1;
    rsp_q.delete();
    apb_q.delete();
    #1 chk_all_zero("mid_reset");
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1 chk("cmd_ready_after_rerelease", 32'(cmd_ready), 32'h1);
    send(1'b0, 32'h8000_0000, 32'h0, 4'b0001, 32'h25A5_A5A5, a1);
    idle();
    drain();

    repeat (4) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
